// File: rtl/sdram_burst_write_if.sv
// Engine-side bundle: SDRAM command/data outputs, controller handshake and write-FIFO port.
interface sdram_burst_write_if #(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 12,
    parameter int COL_WIDTH  = 8
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic [2:0]                                command;
    logic [ROW_WIDTH-1:0]                      address;
    logic [BANK_WIDTH-1:0]                     bank;
    logic [DATA_WIDTH-1:0]                     data_out;
    logic [MASK_WIDTH-1:0]                     data_mask;
    logic                                      idle;
    logic                                      enable;
    logic                                      auto_refresh;
    logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] app_address;
    logic [2*DATA_WIDTH+2*MASK_WIDTH-1:0]      fifo_data;
    logic                                      fifo_read;
    logic                                      fifo_empty;

    modport master (
        output command, address, bank, data_out, data_mask, idle, fifo_read,
        input  enable, auto_refresh, app_address, fifo_data, fifo_empty
    );

    modport slave (
        input  command, address, bank, data_out, data_mask, idle, fifo_read,
        output enable, auto_refresh, app_address, fifo_data, fifo_empty
    );
endinterface

// File: rtl/sdram_burst_write.sv
// Drains the write FIFO into one open row as gapless 2-beat WRITEs, then PRE; resumes after refresh.
// Registered outputs; FIFO is prefetched one word ahead, bursts end early on empty/refresh/row end.
module sdram_burst_write #(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 12,
    parameter int COL_WIDTH  = 8,
    parameter int MAX_WORDS  = 8,
    parameter bit MASK_EN    = 1'b1,
    parameter int T_RCD      = 2,
    parameter int T_WR       = 2,
    parameter int T_RP       = 2
) (
    input logic             clk,
    input logic             rst,
    sdram_burst_write_if.master bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int CNT_WIDTH  = $clog2(MAX_WORDS + 1);
    localparam int DLY_MAX    = (T_RCD > T_WR) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                               : ((T_WR > T_RP) ? T_WR : T_RP);
    localparam int DLY_WIDTH  = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_ACTIVE, S_WR_HI, S_WR_LO, S_PRECHARGE, S_NEXT, S_REFRESH_WAIT
    } state_t;

    state_t                state;
    logic [DLY_WIDTH-1:0]  delay;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  last;
    logic [DATA_WIDTH-1:0] lo_data;
    logic [MASK_WIDTH-1:0] lo_mask;

    logic [BANK_WIDTH-1:0] wr_bank;
    logic [ROW_WIDTH-1:0]  wr_row;
    logic [COL_WIDTH-1:0]  wr_col;
    logic                  col_wrap;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] f_data_lo;
    logic [DATA_WIDTH-1:0] f_data_hi;
    logic [MASK_WIDTH-1:0] f_mask_lo;
    logic [MASK_WIDTH-1:0] f_mask_hi;

    assign wr_bank = wr_addr[ADDR_WIDTH-1 -: BANK_WIDTH];
    assign wr_row  = wr_addr[COL_WIDTH +: ROW_WIDTH];
    assign wr_col  = wr_addr[COL_WIDTH-1:0];

    // col+2 overflows the row exactly when every column bit above bit 0 is set
    assign col_wrap  = &wr_col[COL_WIDTH-1:1];
    assign burst_end = (word_cnt == CNT_WIDTH'(MAX_WORDS - 1)) | col_wrap
                     | bus.fifo_empty | bus.auto_refresh;

    assign f_data_lo = bus.fifo_data[DATA_WIDTH-1:0];
    assign f_data_hi = bus.fifo_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign f_mask_lo = MASK_EN ? bus.fifo_data[2*DATA_WIDTH +: MASK_WIDTH] : '0;
    assign f_mask_hi = MASK_EN ? bus.fifo_data[2*DATA_WIDTH+MASK_WIDTH +: MASK_WIDTH] : '0;

    assign bus.idle = (delay == '0) && ((state == S_IDLE) || (state == S_REFRESH_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            delay         <= '0;
            wr_addr       <= '0;
            word_cnt      <= '0;
            last          <= 1'b0;
            lo_data       <= '0;
            lo_mask       <= '0;
            bus.command   <= CMD_NOP;
            bus.address   <= '0;
            bus.bank      <= '0;
            bus.data_out  <= '0;
            bus.data_mask <= '0;
            bus.fifo_read <= 1'b0;
        end else begin
            bus.command   <= CMD_NOP;
            bus.data_out  <= '0;
            bus.data_mask <= '0;
            bus.fifo_read <= 1'b0;
            if (delay != '0) begin
                delay <= delay - 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.enable && !bus.fifo_empty) begin
                            wr_addr <= bus.app_address;
                            state   <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        bus.command   <= CMD_ACTIVE;
                        bus.bank      <= wr_bank;
                        bus.address   <= wr_row;
                        bus.fifo_read <= 1'b1;
                        word_cnt      <= '0;
                        delay         <= DLY_WIDTH'(T_RCD);
                        state         <= S_WR_HI;
                    end
                    S_WR_HI: begin
                        bus.command   <= CMD_WRITE;
                        bus.address   <= ROW_WIDTH'(wr_col);
                        bus.data_out  <= f_data_hi;
                        bus.data_mask <= f_mask_hi;
                        // low half is captured now so the prefetch pop cannot disturb it
                        lo_data       <= f_data_lo;
                        lo_mask       <= f_mask_lo;
                        last          <= burst_end;
                        bus.fifo_read <= !burst_end;
                        state         <= S_WR_LO;
                    end
                    S_WR_LO: begin
                        bus.data_out  <= lo_data;
                        bus.data_mask <= lo_mask;
                        wr_addr       <= wr_addr + ADDR_WIDTH'(2);
                        word_cnt      <= word_cnt + 1'b1;
                        if (last) begin
                            delay <= DLY_WIDTH'(T_WR);
                            state <= S_PRECHARGE;
                        end else begin
                            state <= S_WR_HI;
                        end
                    end
                    S_PRECHARGE: begin
                        // bank still holds the open row's bank; wr_addr may already point past it
                        bus.command <= CMD_PRECHARGE;
                        bus.address <= '0;
                        delay       <= DLY_WIDTH'(T_RP - 1);
                        state       <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (bus.fifo_empty)        state <= S_IDLE;
                        else if (bus.auto_refresh) state <= S_REFRESH_WAIT;
                        else                       state <= S_ACTIVE;
                    end
                    S_REFRESH_WAIT: begin
                        if (bus.fifo_empty)         state <= S_IDLE;
                        else if (!bus.auto_refresh) state <= S_ACTIVE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdram_burst_write.sv
// Scoreboarded bench for sdram_burst_write: FIFO model, bus-event monitor, directed bursts.
`timescale 1ns/1ps
module tb_sdram_burst_write;
    localparam int DW = 16, BW = 2, RW = 12, CW = 8, MW = DW / 8, AW = BW + RW + CW;
    localparam int MAXW = 8, TRCD = 2, TWR = 2, TRP = 2;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, WRITE = 3'b100, PRE = 3'b010;
    localparam int K_ACT = 0, K_WR = 1, K_LO = 2, K_PRE = 3, K_OTHER = 4;

    typedef struct {
        int              kind;
        logic [2:0]      cmd;
        logic [BW-1:0]   bank;
        logic [RW-1:0]   addr;
        logic [DW-1:0]   dat;
        logic [MW-1:0]   msk;
        int              gap;
    } ev_t;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [MW-1:0] mh;
        logic [MW-1:0] ml;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_burst_write_if #(.DATA_WIDTH(DW), .BANK_WIDTH(BW), .ROW_WIDTH(RW), .COL_WIDTH(CW)) bus ();
    sdram_burst_write_if #(.DATA_WIDTH(DW), .BANK_WIDTH(BW), .ROW_WIDTH(RW), .COL_WIDTH(CW)) bus_nm ();

    sdram_burst_write #(
        .DATA_WIDTH(DW), .BANK_WIDTH(BW), .ROW_WIDTH(RW), .COL_WIDTH(CW), .MAX_WORDS(MAXW),
        .MASK_EN(1'b1), .T_RCD(TRCD), .T_WR(TWR), .T_RP(TRP)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    sdram_burst_write #(
        .DATA_WIDTH(DW), .BANK_WIDTH(BW), .ROW_WIDTH(RW), .COL_WIDTH(CW), .MAX_WORDS(MAXW),
        .MASK_EN(1'b0), .T_RCD(TRCD), .T_WR(TWR), .T_RP(TRP)
    ) dut_nm (.clk(clk), .rst(rst), .bus(bus_nm));

    assign bus_nm.enable       = bus.enable;
    assign bus_nm.auto_refresh = bus.auto_refresh;
    assign bus_nm.app_address  = bus.app_address;
    assign bus_nm.fifo_data    = bus.fifo_data;
    assign bus_nm.fifo_empty   = bus.fifo_empty;

    int    n_tests = 0;
    int    n_fail  = 0;
    ev_t   eq[$];
    word_t fq[$];
    word_t wq[$];
    word_t pw;
    int    pop_err = 0;
    int    wid = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: a pulse seen at an edge presents the next word after that edge
    always @(posedge clk) begin
        if (bus.fifo_read) begin
            if (fq.size() == 0) begin
                pop_err++;
            end else begin
                pw = fq.pop_front();
                bus.fifo_data <= {pw.mh, pw.ml, pw.hi, pw.lo};
            end
        end
    end

    always @(negedge clk) bus.fifo_empty = (fq.size() == 0);

    int gap = 0, cyc = 0, pre_cyc = 0, idle_rise_cyc = 0, rd_cnt = 0, viol = 0;
    bit prev_wr = 1'b0, prev_rd = 1'b0, prev_idle = 1'b0;

    task automatic take_event(input int kind);
        ev_t   e;
        string kn;
        if (eq.size() == 0) begin
            chk("unexpected_event_queue_depth", 32'(eq.size()), 32'd1);
            gap = 0;
            return;
        end
        e  = eq.pop_front();
        kn = (e.kind == K_ACT) ? "act" : (e.kind == K_WR) ? "wr" : (e.kind == K_LO) ? "lo" : "pre";
        chk({kn, "_kind"}, 32'(kind), 32'(e.kind));
        chk({kn, "_cmd"}, 32'(bus.command), 32'(e.cmd));
        if (e.kind != K_LO) chk({kn, "_bank"}, 32'(bus.bank), 32'(e.bank));
        if (e.kind == K_PRE) chk("pre_a10", 32'(bus.address[10]), 32'd0);
        else if (e.kind != K_LO) chk({kn, "_addr"}, 32'(bus.address), 32'(e.addr));
        chk({kn, "_data"}, 32'(bus.data_out), 32'(e.dat));
        chk({kn, "_mask"}, 32'(bus.data_mask), 32'(e.msk));
        if (e.gap >= 0) chk({kn, "_gap"}, 32'(gap), 32'(e.gap));
        gap = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        gap++;
        if (bus.fifo_read) begin
            rd_cnt++;
            if (prev_rd) viol++;
        end
        prev_rd = bus.fifo_read;
        if (bus_nm.data_mask != '0) viol++;
        if (bus.idle && !prev_idle) idle_rise_cyc = cyc;
        prev_idle = bus.idle;
        if (prev_wr) begin
            take_event(K_LO);
        end else if (bus.command != NOP) begin
            take_event((bus.command == ACT) ? K_ACT : (bus.command == WRITE) ? K_WR :
                       (bus.command == PRE) ? K_PRE : K_OTHER);
        end else if (bus.data_out != '0 || bus.data_mask != '0) begin
            viol++;
        end
        if (bus.command == PRE) pre_cyc = cyc;
        prev_wr = (bus.command == WRITE);
    end

    task automatic exp_ev(input int kind, input logic [2:0] cmd, input int b, input int a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m, input int g);
        ev_t e;
        e.kind = kind; e.cmd = cmd; e.bank = BW'(b); e.addr = RW'(a);
        e.dat = d; e.msk = m; e.gap = g;
        eq.push_back(e);
    endtask

    task automatic exp_burst(input int b, input int row, input int col, input int n, input int act_gap);
        word_t w;
        exp_ev(K_ACT, ACT, b, row, '0, '0, act_gap);
        for (int i = 0; i < n; i++) begin
            w = wq.pop_front();
            exp_ev(K_WR, WRITE, b, col + 2 * i, w.hi, w.mh, (i == 0) ? TRCD + 1 : 1);
            exp_ev(K_LO, NOP, b, 0, w.lo, w.ml, 1);
        end
        exp_ev(K_PRE, PRE, b, 0, '0, '0, TWR + 1);
    endtask

    task automatic add_word(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                            input logic [MW-1:0] mh, input logic [MW-1:0] ml);
        word_t w;
        w.hi = hi; w.lo = lo; w.mh = mh; w.ml = ml;
        fq.push_back(w);
        wq.push_back(w);
    endtask

    task automatic add_words(input int n);
        for (int i = 0; i < n; i++) begin
            wid++;
            add_word(16'hA000 | 16'(wid), 16'h5000 | 16'(wid), MW'(wid), MW'(wid >> 1));
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int b, input int r, input int c);
        return {BW'(b), RW'(r), CW'(c)};
    endfunction

    task automatic start(input string tag, input logic [AW-1:0] a);
        int n;
        @(negedge clk);
        bus.app_address = a;
        bus.enable      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 20 && bus.idle);
        chk({tag, "_started"}, 32'(bus.idle), 32'd0);
        bus.enable      = 1'b0;
        bus.app_address = '1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(eq.size() == 0 && bus.idle)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_pending"}, 32'(eq.size()), 32'd0);
        chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (n < 60 && bus.command != WRITE) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_write_seen"}, 32'(bus.command), 32'(WRITE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int    rd0;
    word_t w0;

    initial begin
        bus.enable       = 1'b0;
        bus.auto_refresh = 1'b0;
        bus.app_address  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(bus.command), 32'(NOP));
        chk("rst_addr", 32'(bus.address), 32'd0);
        chk("rst_bank", 32'(bus.bank), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_mask", 32'(bus.data_mask), 32'd0);
        chk("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        rst = 1'b0;

        // single word at 0x012345
        rd0 = rd_cnt;
        add_words(1);
        exp_burst(0, 'h123, 'h45, 1, -1);
        start("single", 22'h012345);
        wait_done("single", 100);
        chk("single_idle_after_pre", 32'(idle_rise_cyc - pre_cyc), 32'(TRP));
        chk("single_rd_pulses", 32'(rd_cnt - rd0), 32'd1);

        // 10 words split by MAX_WORDS
        rd0 = rd_cnt;
        add_words(10);
        exp_burst(1, 'h2AA, 'h10, 8, -1);
        exp_burst(1, 'h2AA, 'h20, 2, TRP + 1);
        start("max", mk_addr(1, 'h2AA, 'h10));
        wait_done("max", 200);
        chk("max_rd_pulses", 32'(rd_cnt - rd0), 32'd10);

        // row end at column 0xFE
        rd0 = rd_cnt;
        add_words(4);
        exp_burst(2, 'h0FF, 'hFC, 2, -1);
        exp_burst(2, 'h100, 'h00, 2, TRP + 1);
        start("rowend", mk_addr(2, 'h0FF, 'hFC));
        wait_done("rowend", 150);
        chk("rowend_rd_pulses", 32'(rd_cnt - rd0), 32'd4);

        // row end carrying into the bank field; PRE must close the old bank
        add_words(2);
        exp_burst(0, 'hFFF, 'hFE, 1, -1);
        exp_burst(1, 'h000, 'h00, 1, TRP + 1);
        start("bankcarry", mk_addr(0, 'hFFF, 'hFE));
        wait_done("bankcarry", 150);

        // auto_refresh raised during word 1, honoured at word 2
        rd0 = rd_cnt;
        add_words(6);
        exp_burst(3, 'h055, 'h80, 2, -1);
        start("refresh", mk_addr(3, 'h055, 'h80));
        wait_write("refresh");
        bus.auto_refresh = 1'b1;
        wait_done("refresh_close", 100);
        repeat (6) @(negedge clk);
        chk("refresh_wait_idle", 32'(bus.idle), 32'd1);
        exp_burst(3, 'h055, 'h84, 4, -1);
        bus.auto_refresh = 1'b0;
        wait_done("refresh_resume", 150);
        chk("refresh_rd_pulses", 32'(rd_cnt - rd0), 32'd6);

        // byte masks on each beat
        add_word(16'h1234, 16'h5678, 2'b01, 2'b10);
        exp_burst(0, 'h010, 'h20, 1, -1);
        start("mask", mk_addr(0, 'h010, 'h20));
        wait_done("mask", 100);

        // reset while the low beat is due
        rd0 = rd_cnt;
        add_words(3);
        w0 = wq[0];
        exp_ev(K_ACT, ACT, 2, 'h333, '0, '0, -1);
        exp_ev(K_WR, WRITE, 2, 'h40, w0.hi, w0.mh, TRCD + 1);
        exp_ev(K_LO, NOP, 2, 0, '0, '0, 1);
        start("midrst", mk_addr(2, 'h333, 'h40));
        wait_write("midrst");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd", 32'(bus.command), 32'(NOP));
        chk("midrst_addr", 32'(bus.address), 32'd0);
        chk("midrst_bank", 32'(bus.bank), 32'd0);
        chk("midrst_data", 32'(bus.data_out), 32'd0);
        chk("midrst_mask", 32'(bus.data_mask), 32'd0);
        chk("midrst_fifo_read", 32'(bus.fifo_read), 32'd0);
        chk("midrst_idle", 32'(bus.idle), 32'd1);
        rst = 1'b0;
        fq.delete();
        wq.delete();
        repeat (8) @(negedge clk);
        chk("midrst_rd_pulses", 32'(rd_cnt - rd0), 32'd2);
        chk("midrst_stays_idle", 32'(bus.idle), 32'd1);

        chk("leftover_expected", 32'(eq.size()), 32'd0);
        chk("fifo_underflow", 32'(pop_err), 32'd0);
        chk("bus_rule_violations", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
